// File: rtl/spi_slave_mailbox_pkg.sv
// rtl/spi_slave_mailbox_pkg.sv - register numbers, engine states and status packing for the SPI mailbox
package spi_slave_mailbox_pkg;

    localparam logic [7:0] SPISLVDATA = 8'hF8;
    localparam logic [7:0] SPISLVSTAT = 8'hF9;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } eng_state_t;

    // Only the low three bits of the fill level are visible in the status byte.
    function automatic logic [2:0] cnt3(input int count);
        return 3'(count);
    endfunction

    function automatic logic [7:0] status_byte(input logic [2:0] rx_count, input logic cs_active,
                                               input logic overrun, input logic tx_valid,
                                               input logic rx_not_empty);
        return {1'b0, rx_count, cs_active, overrun, ~tx_valid, rx_not_empty};
    endfunction

endpackage

// File: rtl/spi_slave_mailbox_if.sv
// rtl/spi_slave_mailbox_if.sv - ZXUNO register bus seen by the SPI mailbox
interface spi_slave_mailbox_if;
    logic [7:0] addr;
    logic       ior;
    logic       iow;
    logic [7:0] din;
    logic [7:0] dout;
    logic       oe;

    modport master (output addr, ior, iow, din, input dout, oe);
    modport slave  (input addr, ior, iow, din, output dout, oe);
endinterface

// File: rtl/spi_slave_mailbox_byte_fifo.sv
// rtl/spi_slave_mailbox_byte_fifo.sv - synchronous byte FIFO, pop-before-push when full
module byte_fifo #(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    // Pop on empty is ignored; a same-cycle pop makes room for a push into a full FIFO.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; pointers and fill level are.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/spi_slave_mailbox.sv
// rtl/spi_slave_mailbox.sv - SPI mode-0 responder exchanging bytes with the CPU via two registers
module spi_slave_mailbox
    import spi_slave_mailbox_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] IDLE_TX_BYTE = 8'hFF
) (
    input  logic                clk,
    input  logic                rst,
    spi_slave_mailbox_if.slave  bus,
    input  logic                spi_sclk,
    input  logic                spi_cs_n,
    input  logic                spi_mosi,
    output logic                spi_miso
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // pipe[0] metastability, pipe[1] synchronised, pipe[2] history
    logic [2:0]  sclk_pipe_q, sclk_pipe_d;
    logic [2:0]  cs_pipe_q, cs_pipe_d;
    logic [1:0]  mosi_pipe_q, mosi_pipe_d;
    eng_state_t  state_q, state_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [6:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [7:0]  tx_hold_q, tx_hold_d;
    logic        tx_valid_q, tx_valid_d;
    logic        byte_done_q, byte_done_d;
    logic        overrun_q, overrun_d;
    logic [2:0]  acc_req_q, acc_req_d;

    logic        sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;
    logic        data_sel, stat_sel;
    logic [2:0]  acc_stb;
    logic        tx_load, fifo_push;
    logic [7:0]  fifo_dout;
    logic [CW-1:0] fifo_count;
    logic        fifo_full, fifo_empty;

    assign sck_rise = sclk_pipe_q[1] & ~sclk_pipe_q[2];
    assign sck_fall = ~sclk_pipe_q[1] & sclk_pipe_q[2];
    assign cs_fall  = ~cs_pipe_q[1] & cs_pipe_q[2];
    assign cs_rise  = cs_pipe_q[1] & ~cs_pipe_q[2];
    assign mosi_s   = mosi_pipe_q[1];
    assign data_sel = (bus.addr == SPISLVDATA);
    assign stat_sel = (bus.addr == SPISLVSTAT);
    // acc_stb: [2] data read, [1] status read, [0] data write
    assign acc_stb  = acc_req_d & ~acc_req_q;

    // Synchronisers and access-request history.
    always_comb begin
        sclk_pipe_d = {sclk_pipe_q[1:0], spi_sclk};
        cs_pipe_d   = {cs_pipe_q[1:0], spi_cs_n};
        mosi_pipe_d = {mosi_pipe_q[0], spi_mosi};
        acc_req_d   = {bus.ior & data_sel, bus.ior & stat_sel, bus.iow & data_sel};
    end

    // Engine next state: CS edges alone frame a transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cs_fall) state_d = ST_SHIFT;
            ST_SHIFT: if (cs_rise) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Shift datapath, TX hold register and overrun flag; CS strobes win over SCLK strobes.
    always_comb begin
        bitcnt_d    = bitcnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        tx_hold_d   = tx_hold_q;
        tx_valid_d  = tx_valid_q;
        byte_done_d = byte_done_q;
        tx_load     = 1'b0;
        fifo_push   = 1'b0;
        if (state_q == ST_IDLE) begin
            if (cs_fall) begin
                bitcnt_d    = 3'd0;
                byte_done_d = 1'b0;
                tx_load     = 1'b1;
            end
        end else if (cs_rise) begin
            bitcnt_d    = 3'd0;
            byte_done_d = 1'b0;
        end else begin
            if (sck_rise) begin
                rx_shift_d = {rx_shift_q[5:0], mosi_s};
                bitcnt_d   = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    fifo_push   = 1'b1;
                    byte_done_d = 1'b1;
                end
            end
            if (sck_fall) begin
                if (byte_done_q) begin
                    tx_load     = 1'b1;
                    byte_done_d = 1'b0;
                end else begin
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
            end
        end
        // The load sees the old hold state; a same-cycle CPU write stays pending.
        if (tx_load) begin
            tx_shift_d = tx_valid_q ? tx_hold_q : IDLE_TX_BYTE;
            tx_valid_d = 1'b0;
        end
        if (acc_stb[0]) begin
            tx_hold_d  = bus.din;
            tx_valid_d = 1'b1;
        end
        overrun_d = (overrun_q & ~acc_stb[1]) | (fifo_push & fifo_full & ~acc_stb[2]);
    end

    // All registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_pipe_q <= 3'b000;
            cs_pipe_q   <= 3'b000;
            mosi_pipe_q <= 2'b00;
            state_q     <= ST_IDLE;
            bitcnt_q    <= 3'd0;
            rx_shift_q  <= 7'd0;
            tx_shift_q  <= IDLE_TX_BYTE;
            tx_hold_q   <= 8'd0;
            tx_valid_q  <= 1'b0;
            byte_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            acc_req_q   <= 3'b000;
        end else begin
            sclk_pipe_q <= sclk_pipe_d;
            cs_pipe_q   <= cs_pipe_d;
            mosi_pipe_q <= mosi_pipe_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_hold_q   <= tx_hold_d;
            tx_valid_q  <= tx_valid_d;
            byte_done_q <= byte_done_d;
            overrun_q   <= overrun_d;
            acc_req_q   <= acc_req_d;
        end
    end

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (acc_stb[2]),
        .din   ({rx_shift_q, mosi_s}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Read mux and MISO drive.
    always_comb begin
        bus.oe   = bus.ior && (data_sel || stat_sel);
        bus.dout = 8'hFF;
        if (bus.ior && data_sel && !fifo_empty) begin
            bus.dout = fifo_dout;
        end else if (bus.ior && stat_sel) begin
            bus.dout = status_byte(cnt3(int'(fifo_count)), ~cs_pipe_q[1], overrun_q,
                                   tx_valid_q, ~fifo_empty);
        end
        spi_miso = (state_q == ST_SHIFT && !cs_pipe_q[1]) ? tx_shift_q[7] : 1'b1;
    end

endmodule
